// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit.
//   ctrl_t     : 8-bit decoded control bundle carried down the pipeline
//   BUBBLE     : all-zero control bundle loaded on a stall or branch squash
//   fwd_sel_t  : EX operand select (FWD_REG regfile, FWD_WB, FWD_MEM)
package pipeline_ctrl_pkg;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// ID-stage decode bundle handed from the decoder to the pipeline control unit.
//   master : decoder side, drives the control bits and register fields
//   slave  : pipeline_ctrl_unit side, consumes them
// Parameter REG_ADDR_W : register-address width.
interface pipeline_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_branch;
    logic                  id_memread;
    logic                  id_memtoreg;
    logic                  id_memwrite;
    logic                  id_alusrc;
    logic                  id_regwrite;
    logic [1:0]            id_aluop;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;

    modport master (
        output id_branch, id_memread, id_memtoreg, id_memwrite,
               id_alusrc, id_regwrite, id_aluop, id_rs1, id_rs2, id_rd
    );

    modport slave (
        input  id_branch, id_memread, id_memtoreg, id_memwrite,
               id_alusrc, id_regwrite, id_aluop, id_rs1, id_rs2, id_rd
    );
endinterface

// File: rtl/pipeline_ctrl_unit_hazard_detect.sv
// Combinational hazard unit: load-use / RAW stall, taken-branch detection
// and EX-stage forwarding selects.
// Build option FORWARDING_EN: when defined, MEM/WB forwarding is active and
// only a load-use stalls; when undefined, forwards are tied to FWD_REG and
// any pending write in EX or MEM to a source register stalls.
// Ports: ex_* / mem_* / wb_* pipeline-register state, id_rs1/id_rs2 from ID;
//        stall, branch_taken, forward_a, forward_b outputs.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_branch,
    input  logic                  ex_zero,
    input  logic                  ex_memread,
`ifndef FORWARDING_EN
    input  logic                  ex_regwrite,
`endif
    input  logic [REG_ADDR_W-1:0] ex_rd,
`ifdef FORWARDING_EN
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
`endif
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  stall,
    output logic                  branch_taken,
    output fwd_sel_t              forward_a,
    output fwd_sel_t              forward_b
);

    // A pending write to a non-zero register that one of the ID sources reads.
    function automatic logic src_hit(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

`ifdef FORWARDING_EN
    function automatic fwd_sel_t fwd_sel(
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_dst,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_dst,
        input logic [REG_ADDR_W-1:0] rs
    );
        if (mem_we && (mem_dst != '0) && (mem_dst == rs)) return FWD_MEM;
        if (wb_we && (wb_dst != '0) && (wb_dst == rs))   return FWD_WB;
        return FWD_REG;
    endfunction
`endif

    logic load_use;

    always_comb begin
        branch_taken = ex_branch & ex_zero;
        load_use     = src_hit(ex_memread, ex_rd, id_rs1, id_rs2);
`ifdef FORWARDING_EN
        stall     = load_use;
        forward_a = fwd_sel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs1);
        forward_b = fwd_sel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs2);
`else
        stall     = load_use
                  | src_hit(ex_regwrite, ex_rd, id_rs1, id_rs2)
                  | src_hit(mem_regwrite, mem_rd, id_rs1, id_rs2);
        forward_a = FWD_REG;
        forward_b = FWD_REG;
`endif
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control unit for the 5-stage core: carries the decoded control
// bundle and register addresses through ID/EX, EX/MEM and MEM/WB, inserts
// load-use bubbles, flushes on taken branches, drives EX forwarding selects
// and keeps a saturating stall-cycle counter.
// Build option FORWARDING_EN selects forwarding vs. full RAW stalling.
// Ports: clk, reset (sync, active-low), id (decode bundle, slave modport),
//        ex_zero; ex_*/mem_*/wb_* pipeline-register outputs, pc_write,
//        ifid_write, ifid_flush, forward_a/b, stall_count.
module pipeline_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_ctrl_unit_if.slave   id,
    input  logic                  ex_zero,
    output logic                  ex_alusrc,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_memtoreg,
    output logic                  ex_branch,
    output logic [1:0]            ex_aluop,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_count
);

    ctrl_t                 id_ctrl;
    ctrl_t                 idex_ctrl;
    logic [REG_ADDR_W-1:0] idex_rd;
`ifdef FORWARDING_EN
    // Source fields only matter to the forwarding selects.
    logic [REG_ADDR_W-1:0] idex_rs1;
    logic [REG_ADDR_W-1:0] idex_rs2;
`endif
    logic                  exmem_regwrite;
    logic                  exmem_memread;
    logic                  exmem_memwrite;
    logic                  exmem_memtoreg;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  memwb_regwrite;
    logic                  memwb_memtoreg;
    logic [REG_ADDR_W-1:0] memwb_rd;

    logic     stall;
    logic     branch_taken;
    logic     stall_hold;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    always_comb begin
        id_ctrl.branch   = id.id_branch;
        id_ctrl.memread  = id.id_memread;
        id_ctrl.memtoreg = id.id_memtoreg;
        id_ctrl.memwrite = id.id_memwrite;
        id_ctrl.alusrc   = id.id_alusrc;
        id_ctrl.regwrite = id.id_regwrite;
        id_ctrl.aluop    = id.id_aluop;
    end

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .ex_branch   (idex_ctrl.branch),
        .ex_zero     (ex_zero),
        .ex_memread  (idex_ctrl.memread),
`ifndef FORWARDING_EN
        .ex_regwrite (idex_ctrl.regwrite),
`endif
        .ex_rd       (idex_rd),
`ifdef FORWARDING_EN
        .ex_rs1      (idex_rs1),
        .ex_rs2      (idex_rs2),
        .wb_regwrite (memwb_regwrite),
        .wb_rd       (memwb_rd),
`endif
        .mem_regwrite(exmem_regwrite),
        .mem_rd      (exmem_rd),
        .id_rs1      (id.id_rs1),
        .id_rs2      (id.id_rs2),
        .stall       (stall),
        .branch_taken(branch_taken),
        .forward_a   (fwd_a),
        .forward_b   (fwd_b)
    );

    // A taken branch squashes the stalled ID instruction, so it wins.
    assign stall_hold = stall & ~branch_taken;
    assign pc_write   = reset & ~stall_hold;
    assign ifid_write = reset & ~stall_hold;
    assign ifid_flush = reset & branch_taken;
    assign forward_a  = fwd_a;
    assign forward_b  = fwd_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_ctrl      <= BUBBLE;
            idex_rd        <= '0;
            exmem_regwrite <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            exmem_rd       <= '0;
            memwb_regwrite <= 1'b0;
            memwb_memtoreg <= 1'b0;
            memwb_rd       <= '0;
        end else begin
            // Bubble clears only the control bits; register fields still move.
            idex_ctrl      <= (stall | branch_taken) ? BUBBLE : id_ctrl;
            idex_rd        <= id.id_rd;
            exmem_regwrite <= idex_ctrl.regwrite;
            exmem_memread  <= idex_ctrl.memread;
            exmem_memwrite <= idex_ctrl.memwrite;
            exmem_memtoreg <= idex_ctrl.memtoreg;
            exmem_rd       <= idex_rd;
            memwb_regwrite <= exmem_regwrite;
            memwb_memtoreg <= exmem_memtoreg;
            memwb_rd       <= exmem_rd;
        end
    end

`ifdef FORWARDING_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_rs1 <= '0;
            idex_rs2 <= '0;
        end else begin
            idex_rs1 <= id.id_rs1;
            idex_rs2 <= id.id_rs2;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall_hold && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign ex_alusrc    = idex_ctrl.alusrc;
    assign ex_regwrite  = idex_ctrl.regwrite;
    assign ex_memread   = idex_ctrl.memread;
    assign ex_memwrite  = idex_ctrl.memwrite;
    assign ex_memtoreg  = idex_ctrl.memtoreg;
    assign ex_branch    = idex_ctrl.branch;
    assign ex_aluop     = idex_ctrl.aluop;
    assign mem_memread  = exmem_memread;
    assign mem_memwrite = exmem_memwrite;
    assign wb_memtoreg  = memwb_memtoreg;
    assign wb_regwrite  = memwb_regwrite;
    assign wb_rd        = memwb_rd;

endmodule
